// File: rtl/sample_frame_collector_pkg.sv
// Shared widths, state encoding and frame helpers for the sample frame collector.
package sample_frame_collector_pkg;

  localparam int unsigned DATAWIDTH   = 8;
  localparam int unsigned NUM_SAMPLES = 16;
  localparam int unsigned IDX_W       = $clog2(NUM_SAMPLES);
  localparam int unsigned FRAME_W     = DATAWIDTH * NUM_SAMPLES;

  typedef logic [DATAWIDTH-1:0] sample_t;
  typedef logic [FRAME_W-1:0]   frame_t;
  typedef logic [IDX_W-1:0]     idx_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Returns f with slot k replaced by s.
  function automatic frame_t put_sample(frame_t f, idx_t k, sample_t s);
    frame_t r;
    r = f;
    r[32'(k) * DATAWIDTH +: DATAWIDTH] = s;
    return r;
  endfunction

endpackage

// File: rtl/sample_frame_collector_if.sv
// Sample stream in, frame stream out; master drives samples, slave is the collector.
interface sample_frame_collector_if;
  import sample_frame_collector_pkg::*;

  sample_t in_data;
  logic    in_valid;
  logic    in_sof;
  logic    in_ready;
  frame_t  out_frame;
  logic    out_valid;
  logic    out_ready;
  logic    err_partial;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, out_frame, out_valid, err_partial
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, out_frame, out_valid, err_partial
  );

endinterface

// File: rtl/sample_frame_collector_frame_bank.sv
// NUM_SAMPLES x DATAWIDTH register bank: one indexed write port, full parallel read.
module frame_bank
  import sample_frame_collector_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_en,
  input  idx_t    wr_idx,
  input  sample_t wr_data,
  output frame_t  rd_frame
);

  sample_t bank [NUM_SAMPLES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_SAMPLES); k++) bank[k] <= '0;
    end else if (wr_en) begin
      bank[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_frame = '0;
    for (int k = 0; k < int'(NUM_SAMPLES); k++) rd_frame[k*DATAWIDTH +: DATAWIDTH] = bank[k];
  end

endmodule

// File: rtl/sample_frame_collector.sv
// Packs a valid/ready sample stream into double-buffered NUM_SAMPLES-wide frames.
module sample_frame_collector
  import sample_frame_collector_pkg::*;
(
  input logic Clk,
  input logic rst,
  sample_frame_collector_if.slave bus
);

  state_e state_q, state_d;
  idx_t   idx_q, idx_d, wr_idx;
  frame_t bank_frame, load_frame, out_frame_q;
  logic   out_valid_q, err_q;
  logic   accept, drain, last, load;

  assign bus.in_ready    = (state_q == ST_FILL) & rst;
  assign bus.out_frame   = out_frame_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.err_partial = err_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = out_valid_q & bus.out_ready;

  frame_bank u_fill_bank (
    .clk      (Clk),
    .rst_n    (rst),
    .wr_en    (accept),
    .wr_idx   (wr_idx),
    .wr_data  (bus.in_data),
    .rd_frame (bank_frame)
  );

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  // The completing sample is merged into the load so it reaches out_frame on its own edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load       = 1'b0;
    last       = 1'b0;
    load_frame = bank_frame;
    wr_idx     = bus.in_sof ? '0 : idx_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          last  = (wr_idx == IDX_W'(NUM_SAMPLES - 1));
          idx_d = last ? '0 : wr_idx + idx_t'(1);
          if (last) begin
            if (!out_valid_q || bus.out_ready) begin
              load       = 1'b1;
              load_frame = put_sample(bank_frame, wr_idx, bus.in_data);
            end else begin
              state_d = ST_FULL;
            end
          end
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      out_frame_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= accept & bus.in_sof & (idx_q != '0);
      if (load) begin
        out_frame_q <= load_frame;
        out_valid_q <= 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Directed, table-driven and scoreboarded checks of sample_frame_collector.
module tb_sample_frame_collector;
  import sample_frame_collector_pkg::*;

  logic Clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_count = 0;
  int   err_count = 0;
  bit   mon_en = 1'b0;
  frame_t exp_q[$];

  sample_frame_collector_if bus ();

  sample_frame_collector dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic    v;
    logic    sof;
    sample_t d;
    logic    ordy;
    logic    e_rdy;
    logic    e_ov;
    logic    e_err;
    sample_t e_a;
    sample_t e_p;
  } vec_t;

  task automatic chk(input string name, input frame_t act, input frame_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sof, input sample_t d, input logic ordy);
    bus.in_valid  = v;
    bus.in_sof    = sof;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  function automatic frame_t mk(input int base);
    frame_t f = '0;
    for (int k = 0; k < int'(NUM_SAMPLES); k++) f[k*DATAWIDTH +: DATAWIDTH] = 8'(base + k);
    return f;
  endfunction

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Handshake monitor, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge Clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      hs_count++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL s5_extra_frame: got %h expected none", bus.out_frame);
        end else begin
          chk("s5_frame", bus.out_frame, exp_q.pop_front());
        end
      end
    end
    if (mon_en && bus.err_partial) err_count++;
  end

  initial begin
    vec_t   vt[22];
    frame_t f4;
    int     base;

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", frame_t'(bus.in_ready), '0);
    chk("rst_out_valid", frame_t'(bus.out_valid), '0);
    chk("rst_out_frame", bus.out_frame, '0);
    chk("rst_err", frame_t'(bus.err_partial), '0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready", frame_t'(bus.in_ready), frame_t'(1));

    // Continuous stream with an always-ready consumer.
    for (int s = 1; s <= 32; s++) begin
      drive(1'b1, 1'b0, 8'(s), 1'b1);
      chk("s2_in_ready", frame_t'(bus.in_ready), frame_t'(1));
      tick();
      if (s == 16) begin
        chk("s2_ov1", frame_t'(bus.out_valid), frame_t'(1));
        chk("s2_frame1", bus.out_frame, mk(1));
      end
      if (s == 17) chk("s2_ov_drop", frame_t'(bus.out_valid), '0);
      if (s == 32) begin
        chk("s2_ov2", frame_t'(bus.out_valid), frame_t'(1));
        chk("s2_frame2", bus.out_frame, mk(17));
      end
    end

    // Load-and-drain on the same edge.
    for (int s = 33; s <= 47; s++) begin
      drive(1'b1, 1'b0, 8'(s), 1'b0);
      tick();
    end
    chk("s6_hold_frame", bus.out_frame, mk(17));
    base = hs_count;
    drive(1'b1, 1'b0, 8'd48, 1'b1);
    tick();
    chk("s6_ov", frame_t'(bus.out_valid), frame_t'(1));
    chk("s6_frame", bus.out_frame, mk(33));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("s6_hs_once", frame_t'(hs_count - base), frame_t'(1));
    chk("s6_ov_held", frame_t'(bus.out_valid), frame_t'(1));

    // Asynchronous reset mid-frame with a held output frame.
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 8'(8'h51 + s), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_ov", frame_t'(bus.out_valid), '0);
    chk("mrst_frame", bus.out_frame, '0);
    chk("mrst_in_ready", frame_t'(bus.in_ready), '0);
    chk("mrst_err", frame_t'(bus.err_partial), '0);
    tick();
    chk("mrst_in_ready_hold", frame_t'(bus.in_ready), '0);
    rst = 1'b1;
    tick();
    chk("mrst_rel_in_ready", frame_t'(bus.in_ready), frame_t'(1));
    for (int s = 0; s < 16; s++) begin
      drive(1'b1, 1'b0, 8'(8'h60 + s), 1'b1);
      tick();
    end
    chk("mrst_frame_clean", bus.out_frame, mk(8'h60));
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("mrst_drained", frame_t'(bus.out_valid), '0);

    // Consumer stalled: second frame fills, then the collector back-pressures.
    for (int s = 1; s <= 32; s++) begin
      drive(1'b1, 1'b0, 8'(s), 1'b0);
      chk("s3_in_ready", frame_t'(bus.in_ready), frame_t'(1));
      tick();
    end
    chk("s3_full_in_ready", frame_t'(bus.in_ready), '0);
    chk("s3_ov", frame_t'(bus.out_valid), frame_t'(1));
    chk("s3_frame_held", bus.out_frame, mk(1));
    drive(1'b1, 1'b0, 8'd33, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    chk("s3_still_full", frame_t'(bus.in_ready), '0);
    chk("s3_still_held", bus.out_frame, mk(1));
    drive(1'b1, 1'b0, 8'd33, 1'b1);
    tick();
    chk("s3_swap_frame", bus.out_frame, mk(17));
    chk("s3_swap_ov", frame_t'(bus.out_valid), frame_t'(1));
    chk("s3_swap_in_ready", frame_t'(bus.in_ready), frame_t'(1));
    do_reset();

    // Partial frame dropped by in_sof.
    for (int i = 0; i < 22; i++) begin
      vt[i] = '{v: 1'b1, sof: 1'b0, d: 8'h00, ordy: 1'b1, e_rdy: 1'b1,
                e_ov: 1'b0, e_err: 1'b0, e_a: 8'h00, e_p: 8'h00};
    end
    for (int i = 0; i < 5; i++) vt[i].d = 8'(i + 1);
    vt[0].sof   = 1'b1;
    vt[5].sof   = 1'b1;
    vt[5].d     = 8'hAA;
    vt[5].e_err = 1'b1;
    for (int i = 6; i <= 20; i++) vt[i].d = 8'(8'h10 + i - 6);
    vt[20].e_ov = 1'b1;
    vt[20].e_a  = 8'hAA;
    vt[20].e_p  = 8'h1E;
    vt[21].v    = 1'b0;
    vt[21].e_a  = 8'hAA;
    vt[21].e_p  = 8'h1E;
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].v, vt[i].sof, vt[i].d, vt[i].ordy);
      tick();
      chk($sformatf("s4_rdy_%0d", i), frame_t'(bus.in_ready), frame_t'(vt[i].e_rdy));
      chk($sformatf("s4_ov_%0d", i), frame_t'(bus.out_valid), frame_t'(vt[i].e_ov));
      chk($sformatf("s4_err_%0d", i), frame_t'(bus.err_partial), frame_t'(vt[i].e_err));
      chk($sformatf("s4_a_%0d", i), frame_t'(bus.out_frame[DATAWIDTH-1:0]), frame_t'(vt[i].e_a));
      chk($sformatf("s4_p_%0d", i), frame_t'(bus.out_frame[FRAME_W-1 -: DATAWIDTH]), frame_t'(vt[i].e_p));
    end
    f4 = mk(8'h0F);
    f4[DATAWIDTH-1:0] = 8'hAA;
    chk("s4_full_frame", bus.out_frame, f4);
    do_reset();

    // Random gaps on both sides, scoreboarded.
    begin
      int      si = 0;
      int      pushed = 0;
      int      cyc = 0;
      bit      cur_valid = 1'b0;
      bit      acc;
      frame_t  cur = '0;
      sample_t d;
      mon_en = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      while (pushed < 1000 && cyc < 60000) begin
        if (!cur_valid && ($urandom % 4 != 0)) begin
          case ($urandom % 8)
            0: d = 8'h00;
            1: d = 8'h7F;
            2: d = 8'h80;
            3: d = 8'hFF;
            default: d = 8'($urandom);
          endcase
          cur_valid = 1'b1;
          bus.in_data = d;
          bus.in_sof  = (si == 0);
        end
        bus.in_valid  = cur_valid;
        bus.out_ready = ($urandom % 4 != 0);
        acc = cur_valid && bus.in_ready;
        tick();
        cyc++;
        if (acc) begin
          cur[si*DATAWIDTH +: DATAWIDTH] = bus.in_data;
          cur_valid = 1'b0;
          if (si == int'(NUM_SAMPLES) - 1) begin
            exp_q.push_back(cur);
            pushed++;
            si = 0;
          end else begin
            si++;
          end
        end
      end
      chk("s5_frames_sent", frame_t'(pushed), frame_t'(1000));
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
      tick();
      chk("s5_queue_empty", frame_t'(exp_q.size()), '0);
      chk("s5_no_err", frame_t'(err_count), '0);
      mon_en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
